// File: rtl/epp_port_ctrl.sv
// rtl/epp_port_ctrl.sv - EPP parallel-port slave front end with handshake FSM and register strobes
module epp_port_ctrl #(
   parameter int AW   = 5,
   parameter int SYNC = 2,
   parameter int TMO  = 255
) (
   input  logic          clk,
   input  logic          nReset,
   input  logic          nWrite,
   input  logic          nAddrStr,
   input  logic          nDataStr,
   input  logic [7:0]    pd_in,
   output logic [7:0]    pd_out,
   output logic          pd_oe,
   output logic          epp_wait,
   output logic [AW-1:0] addr,
   output logic          wr_stb,
   output logic [7:0]    wr_data,
   output logic          rd_stb,
   input  logic [7:0]    rd_data,
   output logic          timeout
);

   typedef enum logic [2:0] {IDLE, AWR, ARD, DWR, DRD0, DRD1, ACK} state_t;

   localparam logic [7:0] TMO_C = TMO[7:0];

   logic [SYNC-1:0] nwr_sync_q, nas_sync_q, nds_sync_q;
   logic [SYNC-1:0] warm_q;
   logic            as, ds, wr, warm_ok;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [AW-1:0]   acap_q, acap_d;
   logic [7:0]      pd_out_q, pd_out_d;
   logic            pd_oe_q, pd_oe_d;
   logic            wait_q, wait_d;
   logic [7:0]      wr_data_q, wr_data_d;
   logic            timeout_q, timeout_d;
   logic            data_q, data_d;
   logic            blk_q, blk_d;
   logic [7:0]      cnt_q, cnt_d;

   // Control-pin synchronizers; reset to the inactive (high) level. warm_q marks when
   // the chains hold real pin samples rather than reset values.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         nwr_sync_q <= '1;
         nas_sync_q <= '1;
         nds_sync_q <= '1;
         warm_q     <= '0;
      end else begin
         nwr_sync_q <= {nwr_sync_q[SYNC-2:0], nWrite};
         nas_sync_q <= {nas_sync_q[SYNC-2:0], nAddrStr};
         nds_sync_q <= {nds_sync_q[SYNC-2:0], nDataStr};
         warm_q     <= {warm_q[SYNC-2:0], 1'b1};
      end
   end

   assign as      = ~nas_sync_q[SYNC-1];
   assign ds      = ~nds_sync_q[SYNC-1];
   assign wr      = ~nwr_sync_q[SYNC-1];
   assign warm_ok = warm_q[SYNC-1];

   // State and datapath registers. blk_q starts set so a strobe still low across
   // reset is not mistaken for a new host cycle.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         acap_q    <= '0;
         pd_out_q  <= '0;
         pd_oe_q   <= 1'b0;
         wait_q    <= 1'b0;
         wr_data_q <= '0;
         timeout_q <= 1'b0;
         data_q    <= 1'b0;
         blk_q     <= 1'b1;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         acap_q    <= acap_d;
         pd_out_q  <= pd_out_d;
         pd_oe_q   <= pd_oe_d;
         wait_q    <= wait_d;
         wr_data_q <= wr_data_d;
         timeout_q <= timeout_d;
         data_q    <= data_d;
         blk_q     <= blk_d;
         cnt_q     <= cnt_d;
      end
   end

   // Handshake FSM: next state and register updates.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      acap_d    = acap_q;
      pd_out_d  = pd_out_q;
      pd_oe_d   = pd_oe_q;
      wait_d    = wait_q;
      wr_data_d = wr_data_q;
      timeout_d = timeout_q;
      data_d    = data_q;
      blk_d     = blk_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: begin
            if (blk_q) begin
               if (warm_ok && !as && !ds) blk_d = 1'b0;
            end else if (as) begin
               state_d = wr ? AWR : ARD;
               acap_d  = pd_in[AW-1:0];
               data_d  = 1'b0;
               wait_d  = 1'b1;
            end else if (ds) begin
               state_d = wr ? DWR : DRD0;
               data_d  = 1'b1;
               if (wr) begin
                  wr_data_d = pd_in;
                  wait_d    = 1'b1;
               end
            end
         end
         AWR: begin
            addr_d    = acap_q;
            timeout_d = 1'b0;
            cnt_d     = '0;
            state_d   = ACK;
         end
         ARD: begin
            pd_out_d = 8'(addr_q);
            pd_oe_d  = 1'b1;
            cnt_d    = '0;
            state_d  = ACK;
         end
         DWR: begin
            cnt_d   = '0;
            state_d = ACK;
         end
         DRD0: begin
            wait_d  = 1'b1;
            state_d = DRD1;
         end
         DRD1: begin
            pd_out_d = rd_data;
            pd_oe_d  = 1'b1;
            cnt_d    = '0;
            state_d  = ACK;
         end
         ACK: begin
            if (!as && !ds) begin
               wait_d  = 1'b0;
               pd_oe_d = 1'b0;
               state_d = IDLE;
               if (data_q) addr_d = addr_q + AW'(1);
            end else if (cnt_q == TMO_C) begin
               wait_d    = 1'b0;
               pd_oe_d   = 1'b0;
               timeout_d = 1'b1;
               blk_d     = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (wr) pd_oe_d = 1'b0;
   end

   assign pd_out   = pd_out_q;
   assign pd_oe    = pd_oe_q & ~wr;
   assign epp_wait = wait_q;
   assign addr     = addr_q;
   assign wr_stb   = (state_q == DWR);
   assign rd_stb   = (state_q == DRD0);
   assign wr_data  = wr_data_q;
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_epp_port_ctrl.sv
// tb/tb_epp_port_ctrl.sv - directed vector bench for epp_port_ctrl
module tb_epp_port_ctrl;
   localparam int AW   = 5;
   localparam int SYNC = 2;
   localparam int TMO  = 255;

   logic          clk = 1'b0;
   logic          nReset = 1'b0;
   logic          nWrite = 1'b1;
   logic          nAddrStr = 1'b1;
   logic          nDataStr = 1'b1;
   logic [7:0]    pd_in = 8'h00;
   logic [7:0]    pd_out;
   logic          pd_oe;
   logic          epp_wait;
   logic [AW-1:0] addr;
   logic          wr_stb;
   logic [7:0]    wr_data;
   logic          rd_stb;
   logic [7:0]    rd_data;
   logic          timeout;

   epp_port_ctrl #(.AW(AW), .SYNC(SYNC), .TMO(TMO)) dut (
      .clk(clk), .nReset(nReset), .nWrite(nWrite), .nAddrStr(nAddrStr), .nDataStr(nDataStr),
      .pd_in(pd_in), .pd_out(pd_out), .pd_oe(pd_oe), .epp_wait(epp_wait), .addr(addr),
      .wr_stb(wr_stb), .wr_data(wr_data), .rd_stb(rd_stb), .rd_data(rd_data), .timeout(timeout)
   );

   always #5 clk = ~clk;

   assign rd_data = 8'hA0 + {3'b000, addr};

   int errors = 0;
   int checks = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   int oe_bad = 0;
   logic [AW-1:0] last_wr_addr = '0;
   logic [7:0]    last_wr_data = '0;

   always @(negedge clk) begin
      if (wr_stb) begin
         wr_cnt++;
         last_wr_addr = addr;
         last_wr_data = wr_data;
      end
      if (rd_stb) rd_cnt++;
      if (pd_oe && !epp_wait) oe_bad++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic epp_cycle(input bit is_addr, input bit is_wr, input logic [7:0] din,
                            output int lat, output int rlat, output logic [7:0] pdv, output logic oev);
      @(negedge clk);
      nWrite = !is_wr;
      pd_in  = din;
      if (is_addr) nAddrStr = 1'b0;
      else nDataStr = 1'b0;
      lat = 0;
      while (epp_wait !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      @(negedge clk);
      pdv = pd_out;
      oev = pd_oe;
      nAddrStr = 1'b1;
      nDataStr = 1'b1;
      rlat = 0;
      while (epp_wait !== 1'b0 && rlat < 50) begin
         @(negedge clk);
         rlat++;
      end
      nWrite = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_high(input string name);
      int n = 0;
      while (epp_wait !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check(name, 32'(epp_wait), 32'd1);
   endtask

   task automatic wait_low(input string name);
      int n = 0;
      while (epp_wait !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check(name, 32'(epp_wait), 32'd0);
   endtask

   typedef struct {
      bit            is_addr;
      bit            is_wr;
      logic [7:0]    din;
      logic [7:0]    exp_pd;
      logic [AW-1:0] exp_addr;
      logic [AW-1:0] exp_wr_addr;
      int            exp_lat;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int lat, rlat, w0, r0, hi;
      logic [7:0] pdv;
      logic oev;

      vecs[0]  = '{1'b1, 1'b1, 8'h0B, 8'h00, 5'h0B, 5'h00, SYNC+1};
      vecs[1]  = '{1'b0, 1'b1, 8'h34, 8'h00, 5'h0C, 5'h0B, SYNC+1};
      vecs[2]  = '{1'b0, 1'b1, 8'h12, 8'h00, 5'h0D, 5'h0C, SYNC+1};
      vecs[3]  = '{1'b1, 1'b1, 8'h00, 8'h00, 5'h00, 5'h00, SYNC+1};
      vecs[4]  = '{1'b0, 1'b0, 8'h00, 8'hA0, 5'h01, 5'h00, SYNC+2};
      vecs[5]  = '{1'b0, 1'b0, 8'h00, 8'hA1, 5'h02, 5'h00, SYNC+2};
      vecs[6]  = '{1'b0, 1'b0, 8'h00, 8'hA2, 5'h03, 5'h00, SYNC+2};
      vecs[7]  = '{1'b0, 1'b0, 8'h00, 8'hA3, 5'h04, 5'h00, SYNC+2};
      vecs[8]  = '{1'b1, 1'b0, 8'h00, 8'h04, 5'h04, 5'h00, SYNC+1};
      vecs[9]  = '{1'b1, 1'b1, 8'h1F, 8'h00, 5'h1F, 5'h00, SYNC+1};
      vecs[10] = '{1'b0, 1'b1, 8'h55, 8'h00, 5'h00, 5'h1F, SYNC+1};

      // reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_pd_out", 32'(pd_out), 32'h0);
      check("rst_pd_oe", 32'(pd_oe), 32'h0);
      check("rst_wait", 32'(epp_wait), 32'h0);
      check("rst_addr", 32'(addr), 32'h0);
      check("rst_wr_stb", 32'(wr_stb), 32'h0);
      check("rst_rd_stb", 32'(rd_stb), 32'h0);
      check("rst_wr_data", 32'(wr_data), 32'h0);
      check("rst_timeout", 32'(timeout), 32'h0);
      @(negedge clk);
      nReset = 1'b1;
      repeat (5) @(negedge clk);

      // table-driven host cycles
      for (int i = 0; i < 11; i++) begin
         w0 = wr_cnt;
         r0 = rd_cnt;
         epp_cycle(vecs[i].is_addr, vecs[i].is_wr, vecs[i].din, lat, rlat, pdv, oev);
         check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
         check($sformatf("v%0d_rel_lat", i), 32'(rlat), 32'(SYNC+1));
         check($sformatf("v%0d_addr", i), 32'(addr), 32'(vecs[i].exp_addr));
         check($sformatf("v%0d_wr_cnt", i), 32'(wr_cnt - w0), 32'(!vecs[i].is_addr && vecs[i].is_wr));
         check($sformatf("v%0d_rd_cnt", i), 32'(rd_cnt - r0), 32'(!vecs[i].is_addr && !vecs[i].is_wr));
         if (!vecs[i].is_wr) begin
            check($sformatf("v%0d_pd_out", i), 32'(pdv), 32'(vecs[i].exp_pd));
            check($sformatf("v%0d_pd_oe", i), 32'(oev), 32'd1);
         end else if (!vecs[i].is_addr) begin
            check($sformatf("v%0d_wr_addr", i), 32'(last_wr_addr), 32'(vecs[i].exp_wr_addr));
            check($sformatf("v%0d_wr_data", i), 32'(last_wr_data), 32'(vecs[i].din));
         end
      end

      // both strobes in the same cycle: address cycle wins
      w0 = wr_cnt;
      @(negedge clk);
      nWrite = 1'b0; pd_in = 8'h07; nAddrStr = 1'b0; nDataStr = 1'b0;
      wait_high("both_wait_hi");
      @(negedge clk);
      nAddrStr = 1'b1; nDataStr = 1'b1;
      wait_low("both_wait_lo");
      nWrite = 1'b1;
      repeat (3) @(negedge clk);
      check("both_addr", 32'(addr), 32'h07);
      check("both_no_wr", 32'(wr_cnt - w0), 32'd0);

      // data strobe stuck low: timeout abort
      w0 = wr_cnt;
      @(negedge clk);
      nWrite = 1'b0; pd_in = 8'h66; nDataStr = 1'b0;
      hi = 0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (epp_wait) hi++;
         else if (hi > 0) break;
      end
      check("tmo_wait_cycles", 32'(hi), 32'(TMO+2));
      check("tmo_flag", 32'(timeout), 32'd1);
      check("tmo_addr", 32'(addr), 32'h07);
      hi = 0;
      repeat (10) begin
         @(negedge clk);
         if (epp_wait) hi++;
      end
      check("tmo_no_rewait", 32'(hi), 32'd0);
      check("tmo_wr_cnt", 32'(wr_cnt - w0), 32'd1);
      check("tmo_wr_addr", 32'(last_wr_addr), 32'h07);
      nDataStr = 1'b1; nWrite = 1'b1;
      repeat (5) @(negedge clk);
      check("tmo_addr_after", 32'(addr), 32'h07);
      epp_cycle(1'b1, 1'b1, 8'h03, lat, rlat, pdv, oev);
      check("tmo_cleared", 32'(timeout), 32'd0);
      check("tmo_new_addr", 32'(addr), 32'h03);

      // nWrite flips to write during a read: pd_oe drops once synced
      @(negedge clk);
      nWrite = 1'b1; nDataStr = 1'b0;
      wait_high("flip_wait_hi");
      @(negedge clk);
      check("flip_oe_before", 32'(pd_oe), 32'd1);
      check("flip_pd_out", 32'(pd_out), 32'hA3);
      nWrite = 1'b0;
      repeat (SYNC) @(negedge clk);
      check("flip_oe_after", 32'(pd_oe), 32'd0);
      nDataStr = 1'b1;
      wait_low("flip_wait_lo");
      nWrite = 1'b1;
      repeat (3) @(negedge clk);
      check("flip_addr", 32'(addr), 32'h04);

      // reset during the ACK of a data read
      @(negedge clk);
      nWrite = 1'b1; nDataStr = 1'b0;
      wait_high("rst_rd_wait_hi");
      @(negedge clk);
      check("rstrd_oe_pre", 32'(pd_oe), 32'd1);
      check("rstrd_pd_pre", 32'(pd_out), 32'hA4);
      #1 nReset = 1'b0;
      #1;
      check("rstrd_oe", 32'(pd_oe), 32'd0);
      check("rstrd_wait", 32'(epp_wait), 32'd0);
      check("rstrd_addr", 32'(addr), 32'h00);
      @(negedge clk);
      nReset = 1'b1;
      r0 = rd_cnt;
      w0 = wr_cnt;
      hi = 0;
      repeat (12) begin
         @(negedge clk);
         if (epp_wait) hi++;
      end
      check("rstrd_no_wait", 32'(hi), 32'd0);
      check("rstrd_no_stb", 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);
      nDataStr = 1'b1;
      repeat (5) @(negedge clk);
      epp_cycle(1'b0, 1'b1, 8'h99, lat, rlat, pdv, oev);
      check("post_rst_wr_addr", 32'(last_wr_addr), 32'h00);
      check("post_rst_wr_data", 32'(last_wr_data), 32'h99);
      check("post_rst_addr", 32'(addr), 32'h01);

      check("oe_outside_wait", 32'(oe_bad), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
